// File: rtl/serdes_channel_rx_rate_hunt.sv
// serdes_channel_rx_rate_hunt
// Receive-side rate-hunt and reset sequencer for one SerDes channel.
// Steps through the enabled line rates (highest first, then downwards with
// wrap), pulsing the channel rx reset for each attempt and waiting for the
// K-code sync detector to report sync. Once locked it supervises ksync and
// re-acquires the link at the same rate when sync is lost.
//
// Ports:
//   I_serdes_rx_clk    in   rx clock, the only clock
//   I_serdes_rx_rst_n  in   asynchronous active-low reset
//   I_hunt_en          in   hunting enable; low forces IDLE
//   I_rate_en_mask     in   [9:0] bit n set -> rate code n may be tried
//   I_serdes_rx_ksync  in   sync flag from the K-code sync detector
//   O_serdes_rx_rst    out  active-high rx reset to SerDes and sync detector
//   O_serdes_rate      out  [3:0] current rate code
//   O_rate_locked      out  high while in LOCKED
//   O_lock_loss_pulse  out  one-cycle pulse when loss of sync is declared
//   O_no_rate_err      out  hunting requested but no rate enabled
//   O_hunt_state       out  [2:0] IDLE=0 RESET=1 WAIT_LOCK=2 LOCKED=3 NEXT=4
module serdes_channel_rx_rate_hunt #(
    parameter int          RST_CYC      = 64,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd4_000_000,
    parameter int          LOSS_FILTER  = 16,
    parameter int          RETRY_MAX    = 2
) (
    input  logic       I_serdes_rx_clk,
    input  logic       I_serdes_rx_rst_n,
    input  logic       I_hunt_en,
    input  logic [9:0] I_rate_en_mask,
    input  logic       I_serdes_rx_ksync,
    output logic       O_serdes_rx_rst,
    output logic [3:0] O_serdes_rate,
    output logic       O_rate_locked,
    output logic       O_lock_loss_pulse,
    output logic       O_no_rate_err,
    output logic [2:0] O_hunt_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_NEXT      = 3'd4
    } hunt_state_t;

    // Reset dwell counter counts 0..RST_CYC-1.
    localparam int RST_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    // Loss counter counts 0..LOSS_FILTER and saturates there.
    localparam int LOSS_W = $clog2(LOSS_FILTER + 1);

    localparam logic [RST_W-1:0]  RST_LAST     = RST_W'(RST_CYC - 1);
    localparam logic [RST_W-1:0]  RST_ONE      = RST_W'(1);
    localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX     = LOSS_W'(LOSS_FILTER);
    localparam logic [LOSS_W-1:0] LOSS_ONE     = LOSS_W'(1);
    localparam logic [23:0]       TIMEOUT_LAST = LOCK_TIMEOUT - 24'd1;
    localparam logic [2:0]        RETRY_MAX_C  = 3'(RETRY_MAX);

    // Highest enabled rate code (ascending scan, last hit wins).
    function automatic logic [3:0] highest_rate(input logic [9:0] mask);
        logic [3:0] sel;
        sel = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (mask[i]) begin
                sel = 4'(i);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Next lower enabled code below 'rate'; wraps to the highest enabled
    // code when nothing lower is enabled, so a lone rate reselects itself.
    function automatic logic [3:0] next_lower_rate(input logic [9:0] mask,
                                                   input logic [3:0] rate);
        logic [3:0] sel;
        sel = highest_rate(mask);
        for (int i = 0; i < 10; i++) begin
            if (mask[i] && (4'(i) < rate)) begin
                sel = 4'(i);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    hunt_state_t       state_r, state_s;
    logic [3:0]        rate_r, rate_s;
    logic [2:0]        retry_r, retry_s;
    logic [RST_W-1:0]  rst_cnt_r, rst_cnt_s;
    logic [23:0]       timer_r, timer_s;
    logic [LOSS_W-1:0] loss_r, loss_s;
    logic              rx_rst_r, locked_r, loss_pulse_r, no_rate_err_r;
    logic              loss_pulse_s;
    logic              mask_nz_s;
    logic [15:0]       mask_ext_s;

    assign mask_nz_s  = |I_rate_en_mask;
    // Widened so a 4-bit rate code indexes it without range concerns.
    assign mask_ext_s = {6'd0, I_rate_en_mask};

    // Next-state, counter and rate selection logic.
    always_comb begin
        state_s      = state_r;
        rate_s       = rate_r;
        retry_s      = retry_r;
        rst_cnt_s    = '0;
        timer_s      = '0;
        loss_s       = '0;
        loss_pulse_s = 1'b0;

        if (!I_hunt_en) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mask_nz_s) begin
                        rate_s  = highest_rate(I_rate_en_mask);
                        retry_s = 3'd0;
                        state_s = ST_RESET;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_r == RST_LAST) begin
                        state_s = ST_WAIT_LOCK;
                    end else begin
                        rst_cnt_s = rst_cnt_r + RST_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    // ksync wins over the timeout on the same cycle.
                    if (I_serdes_rx_ksync) begin
                        state_s = ST_LOCKED;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_s = ST_NEXT;
                    end else begin
                        timer_s = timer_r + 24'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!mask_ext_s[rate_r]) begin
                        // Current rate withdrawn: force NEXT to pick another.
                        retry_s = RETRY_MAX_C;
                        state_s = ST_NEXT;
                    end else if (I_serdes_rx_ksync) begin
                        loss_s = '0;
                    end else if (loss_r == LOSS_LAST) begin
                        loss_s       = LOSS_MAX;
                        loss_pulse_s = 1'b1;
                        retry_s      = 3'd0;
                        state_s      = ST_RESET;
                    end else begin
                        loss_s = loss_r + LOSS_ONE;
                    end
                end
                ST_NEXT: begin
                    if (!mask_nz_s) begin
                        state_s = ST_IDLE;
                    end else if (retry_r < RETRY_MAX_C) begin
                        retry_s = retry_r + 3'd1;
                        state_s = ST_RESET;
                    end else begin
                        retry_s = 3'd0;
                        rate_s  = next_lower_rate(I_rate_en_mask, rate_r);
                        state_s = ST_RESET;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge I_serdes_rx_clk or negedge I_serdes_rx_rst_n) begin
        if (!I_serdes_rx_rst_n) begin
            state_r       <= ST_IDLE;
            rate_r        <= 4'd0;
            retry_r       <= 3'd0;
            rst_cnt_r     <= '0;
            timer_r       <= 24'd0;
            loss_r        <= '0;
            rx_rst_r      <= 1'b1;
            locked_r      <= 1'b0;
            loss_pulse_r  <= 1'b0;
            no_rate_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            rate_r        <= rate_s;
            retry_r       <= retry_s;
            rst_cnt_r     <= rst_cnt_s;
            timer_r       <= timer_s;
            loss_r        <= loss_s;
            // Reset is released only while waiting for or holding lock.
            rx_rst_r      <= !((state_s == ST_WAIT_LOCK) || (state_s == ST_LOCKED));
            locked_r      <= (state_s == ST_LOCKED);
            loss_pulse_r  <= loss_pulse_s;
            no_rate_err_r <= I_hunt_en && !mask_nz_s && (state_s == ST_IDLE);
        end
    end

    assign O_serdes_rx_rst   = rx_rst_r;
    assign O_serdes_rate     = rate_r;
    assign O_rate_locked     = locked_r;
    assign O_lock_loss_pulse = loss_pulse_r;
    assign O_no_rate_err     = no_rate_err_r;
    assign O_hunt_state      = state_r;

endmodule

// File: doc/serdes_channel_rx_rate_hunt.md
# serdes_channel_rx_rate_hunt

Receive-side rate-hunt and reset sequencer for one SerDes channel. It drives `O_serdes_rate` and the channel rx reset for the SerDes and the K-code sync detector. It watches the sync detector's `ksync` flag and moves through the enabled line rates until the link synchronises. After lock it supervises the link and re-acquires it when sync is lost.

## Interface
Parameters:
- `RST_CYC`, default 64: cycles `O_serdes_rx_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, default 24'd4_000_000: cycles to wait for ksync after reset release (≥2, ≤2^24-1).
- `LOSS_FILTER`, default 16: consecutive ksync-low cycles in LOCKED that declare loss (≥1).
- `RETRY_MAX`, default 2: extra attempts at the same rate before moving to the next rate (0–7).

Ports:
- `I_serdes_rx_clk`, in, 1: rx clock; the only clock.
- `I_serdes_rx_rst_n`, in, 1: asynchronous active-low reset.
- `I_hunt_en`, in, 1: enables hunting; low forces IDLE.
- `I_rate_en_mask`, in, 10: bit n set means rate code n (0..9) may be tried.
- `I_serdes_rx_ksync`, in, 1: sync flag from the K-code sync detector; high means synced.
- `O_serdes_rx_rst`, out, 1: active-high rx reset to the SerDes and the sync detector.
- `O_serdes_rate`, out, 4: current rate code.
- `O_rate_locked`, out, 1: high while in LOCKED.
- `O_lock_loss_pulse`, out, 1: one-cycle pulse when loss of sync is declared.
- `O_no_rate_err`, out, 1: high while hunting is requested but the mask is zero.
- `O_hunt_state`, out, 3: state code, IDLE=0, RESET=1, WAIT_LOCK=2, LOCKED=3, NEXT=4.

## Operation
- All outputs are registered. Reset values:
  - `O_serdes_rx_rst`=1
  - `O_serdes_rate`=4'd0
  - `O_rate_locked`=0
  - `O_lock_loss_pulse`=0
  - `O_no_rate_err`=0
  - `O_hunt_state`=0 (IDLE)
  - internal counters = 0
- IDLE:
  - `O_serdes_rx_rst`=1.
  - If `I_hunt_en` is high and the mask is nonzero: load the rate with the highest set mask bit, clear the retry count, go to RESET.
  - If `I_hunt_en` is high and the mask is zero: `O_no_rate_err`=1, stay in IDLE.
- RESET:
  - `O_serdes_rx_rst`=1 for exactly `RST_CYC` cycles, then go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - `O_serdes_rx_rst`=0 and the timer increments.
  - If `I_serdes_rx_ksync` is high, go to LOCKED; this takes priority over timeout on the same cycle.
  - If the timer reaches `LOCK_TIMEOUT`-1, go to NEXT.
- NEXT (lasts 1 cycle):
  - If retry count < `RETRY_MAX`: increment the retry count, keep the rate.
  - Otherwise: clear the retry count and select the next lower enabled rate code, wrapping from the lowest back to the highest enabled code. A single enabled rate reselects itself.
  - Then go to RESET.
  - The mask is sampled here. If the mask is zero here, go to IDLE and raise `O_no_rate_err`.
- LOCKED:
  - `O_rate_locked`=1.
  - The loss counter counts consecutive ksync-low cycles and clears on any ksync-high cycle.
  - When the count reaches `LOSS_FILTER`: pulse `O_lock_loss_pulse` for one cycle, clear the retry count, go to RESET at the same rate.
  - If the mask bit for the current rate is cleared: set the retry count to `RETRY_MAX` and go to NEXT, which changes the rate. No loss pulse is issued.
- `I_hunt_en` low in any state gives IDLE on the next cycle. This has the highest priority.
- An async reset mid-hunt aborts immediately to reset values. There is no memory of the last good rate.

## Timing
- `O_serdes_rate` changes only on the IDLE→RESET and NEXT→RESET transitions, so it is stable for the whole reset pulse and the wait that follows.
- Attempt timing:
  - IDLE→RESET: 1 cycle after `I_hunt_en` is seen high.
  - `O_serdes_rx_rst` falls exactly `RST_CYC` cycles after it is entered in RESET.
  - WAIT_LOCK lasts at most `LOCK_TIMEOUT` cycles.
  - NEXT lasts 1 cycle.
- Worst-case cycles per attempt: `RST_CYC`+`LOCK_TIMEOUT`+1.
- `O_rate_locked` rises 1 cycle after ksync is sampled high in WAIT_LOCK.
- Loss timing: `O_lock_loss_pulse` and the fall of `O_rate_locked` both occur `LOSS_FILTER` cycles after the first ksync-low cycle. `O_serdes_rx_rst` rises in the same cycle.
- The timer is 24 bits and must not wrap. The loss counter saturates at `LOSS_FILTER`. The retry counter is 3 bits.

## Test plan
Test parameters: `RST_CYC`=4, `LOCK_TIMEOUT`=20, `LOSS_FILTER`=3, `RETRY_MAX`=1.
- Nominal lock: mask=10'h0A0, hunt_en=1, ksync goes high 5 cycles after reset release → rate=7, rx_rst high exactly 4 cycles, `O_rate_locked`=1 one cycle after ksync, `O_hunt_state`=3.
- Retry then rate step: mask=10'h0A0, ksync held low → two attempts at rate 7 (24 cycles each plus 1 NEXT cycle), then rate 5, then wraps back to 7.
- Loss filter: locked at rate 5; ksync low for 2 cycles then high → stays LOCKED, no pulse. ksync low for 3 cycles → one pulse, rx_rst=1, retry at rate 5.
- Mask edge cases: mask=0 with hunt_en=1 → `O_no_rate_err`=1, IDLE, rx_rst=1. Locked at rate 7, clear bit 7 → NEXT, then rate 5, no loss pulse.
- Priority: ksync rises on the timeout cycle → LOCKED, not NEXT. hunt_en drops in WAIT_LOCK → IDLE next cycle, rx_rst=1.
- Async reset: assert `I_serdes_rx_rst_n`=0 mid-RESET → all outputs return to reset values immediately; after release with hunt_en=1 the hunt restarts at the highest enabled rate.
